// File: rtl/nios_sys_onchip_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : nios_sys_onchip_mem_arbiter_if
// Description : Bus bundle between the two requesters, the arbiter and the
//               on-chip RAM. The slave modport is the arbiter's view; the
//               master modport is the surrounding system's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface nios_sys_onchip_mem_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] m0_address;
    logic              m0_read;
    logic              m0_write;
    logic [3:0]        m0_byteenable;
    logic [31:0]       m0_writedata;
    logic              m0_waitrequest;
    logic [31:0]       m0_readdata;
    logic              m0_readdatavalid;

    logic [ADDR_W-1:0] m1_address;
    logic              m1_read;
    logic              m1_write;
    logic [3:0]        m1_byteenable;
    logic [31:0]       m1_writedata;
    logic              m1_waitrequest;
    logic [31:0]       m1_readdata;
    logic              m1_readdatavalid;

    logic [ADDR_W-1:0] ram_address;
    logic [3:0]        ram_byteenable;
    logic [31:0]       ram_writedata;
    logic              ram_chipselect;
    logic              ram_write;
    logic              ram_clken;
    logic [31:0]       ram_readdata;

    logic              oor_err;

    modport slave (
        input  m0_address, m0_read, m0_write, m0_byteenable, m0_writedata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_read, m1_write, m1_byteenable, m1_writedata,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output ram_address, ram_byteenable, ram_writedata,
        output ram_chipselect, ram_write, ram_clken,
        input  ram_readdata,
        output oor_err
    );

    modport master (
        output m0_address, m0_read, m0_write, m0_byteenable, m0_writedata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_read, m1_write, m1_byteenable, m1_writedata,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  ram_address, ram_byteenable, ram_writedata,
        input  ram_chipselect, ram_write, ram_clken,
        output ram_readdata,
        input  oor_err
    );
endinterface
`default_nettype wire

// File: rtl/nios_sys_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nios_sys_onchip_mem_arbiter
// Description : Two-requester round-robin arbiter in front of a single-port
//               on-chip RAM with 1-cycle read latency. Out-of-range accesses
//               are accepted but never reach the RAM, return zero on reads
//               and set a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module nios_sys_onchip_mem_arbiter #(
    parameter int DEPTH  = 2624,
    parameter int ADDR_W = 12
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    nios_sys_onchip_mem_arbiter_if.slave bus
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    typedef enum logic [0:0] {
        PRI_M0 = 1'b0,
        PRI_M1 = 1'b1
    } prio_t;

    prio_t             r_prio;
    prio_t             w_prio_next;

    logic              w_req0;
    logic              w_req1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any_gnt;
    logic              w_gnt_write;
    logic [ADDR_W-1:0] w_addr;
    logic              w_oor;

    logic              r_pend_valid;
    logic              r_pend_owner;   // 0 = m0, 1 = m1
    logic              r_pend_oor;
    logic              r_oor_err;

    // Request decode and grant: a lone requester always wins, a tie goes to
    // whichever requester the pointer currently favours.
    always_comb begin
        w_req0      = bus.m0_read | bus.m0_write;
        w_req1      = bus.m1_read | bus.m1_write;
        w_gnt0      = w_req0 & (~w_req1 | (r_prio == PRI_M0));
        w_gnt1      = w_req1 & (~w_req0 | (r_prio == PRI_M1));
        w_any_gnt   = w_gnt0 | w_gnt1;
        w_gnt_write = w_gnt1 ? bus.m1_write : (w_gnt0 & bus.m0_write);
        w_addr      = w_gnt1 ? bus.m1_address : bus.m0_address;
        w_oor       = ({1'b0, w_addr} >= c_depth);
    end

    // RAM side: m0 is the default source so the mux has no idle case; access
    // strobes are suppressed for out-of-range addresses and during reset.
    always_comb begin
        bus.ram_address    = w_addr;
        bus.ram_byteenable = w_gnt1 ? bus.m1_byteenable : bus.m0_byteenable;
        bus.ram_writedata  = w_gnt1 ? bus.m1_writedata  : bus.m0_writedata;
        bus.ram_chipselect = w_any_gnt & ~w_oor & ~reset;
        bus.ram_write      = w_any_gnt & w_gnt_write & ~w_oor & ~reset;
        bus.ram_clken      = 1'b1;
    end

    // Requester side: stall the loser, return read data to the pending owner.
    always_comb begin
        bus.m0_waitrequest   = w_req0 & ~w_gnt0 & ~reset;
        bus.m1_waitrequest   = w_req1 & ~w_gnt1 & ~reset;
        bus.m0_readdatavalid = r_pend_valid & ~r_pend_owner;
        bus.m1_readdatavalid = r_pend_valid &  r_pend_owner;
        bus.m0_readdata      = (bus.m0_readdatavalid & ~r_pend_oor) ? bus.ram_readdata : 32'd0;
        bus.m1_readdata      = (bus.m1_readdatavalid & ~r_pend_oor) ? bus.ram_readdata : 32'd0;
        bus.oor_err          = r_oor_err;
    end

    // Priority pointer next state: favour whoever lost the most recent grant.
    always_comb begin
        w_prio_next = r_prio;
        if (w_gnt0) begin
            w_prio_next = PRI_M1;
        end else if (w_gnt1) begin
            w_prio_next = PRI_M0;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio <= PRI_M0;
        end else begin
            r_prio <= w_prio_next;
        end
    end

    // Pending-read slot: one entry suffices because latency is fixed at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_owner <= 1'b0;
            r_pend_oor   <= 1'b0;
        end else begin
            r_pend_valid <= w_any_gnt & ~w_gnt_write;
            r_pend_owner <= w_gnt1;
            r_pend_oor   <= w_oor;
        end
    end

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_oor_err <= 1'b0;
        end else if (w_any_gnt & w_oor) begin
            r_oor_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nios_sys_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios_sys_onchip_mem_arbiter
// Description : Directed self-checking bench for the on-chip RAM arbiter,
//               with a behavioural 1-cycle-latency RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios_sys_onchip_mem_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    nios_sys_onchip_mem_arbiter_if #(.ADDR_W(12)) bus ();

    nios_sys_onchip_mem_arbiter #(
        .DEPTH  (2624),
        .ADDR_W (12)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model: byte-enabled write, registered read (old data on collision).
    logic [31:0] mem [0:4095];
    logic [31:0] r_rd;
    assign bus.ram_readdata = r_rd;

    always @(posedge clk) begin
        if (bus.ram_chipselect && bus.ram_write) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.ram_byteenable[b]) mem[bus.ram_address][b*8 +: 8] <= bus.ram_writedata[b*8 +: 8];
            end
        end
        r_rd <= mem[bus.ram_address];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.m0_read = 1'b0; bus.m0_write = 1'b0;
        bus.m1_read = 1'b0; bus.m1_write = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 | i;
        r_rd = 32'd0;
        bus.m0_address = '0; bus.m0_byteenable = 4'hF; bus.m0_writedata = '0;
        bus.m1_address = '0; bus.m1_byteenable = 4'hF; bus.m1_writedata = '0;
        idle();

        // Reset with both requesting: everything quiet.
        reset = 1'b1;
        bus.m0_read = 1'b1; bus.m1_read = 1'b1;
        #12;
        check("rst_wait0", {31'd0, bus.m0_waitrequest}, 32'd0);
        check("rst_wait1", {31'd0, bus.m1_waitrequest}, 32'd0);
        check("rst_cs",    {31'd0, bus.ram_chipselect}, 32'd0);
        check("rst_rdv",   {30'd0, bus.m1_readdatavalid, bus.m0_readdatavalid}, 32'd0);
        check("rst_oor",   {31'd0, bus.oor_err}, 32'd0);
        check("clken",     {31'd0, bus.ram_clken}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        idle();
        tick();

        // A: simultaneous reads, m0 first.
        bus.m0_read = 1'b1; bus.m0_address = 12'h010;
        bus.m1_read = 1'b1; bus.m1_address = 12'h020;
        #1;
        check("A_wait0", {31'd0, bus.m0_waitrequest}, 32'd0);
        check("A_wait1", {31'd0, bus.m1_waitrequest}, 32'd1);
        check("A_addr0", {20'd0, bus.ram_address}, 32'h010);
        tick();
        bus.m0_read = 1'b0;
        #1;
        check("A_wait1b", {31'd0, bus.m1_waitrequest}, 32'd0);
        check("A_addr1",  {20'd0, bus.ram_address}, 32'h020);
        check("A_rdv0",   {31'd0, bus.m0_readdatavalid}, 32'd1);
        check("A_data0",  bus.m0_readdata, 32'hA500_0010);
        check("A_rdv1n",  {31'd0, bus.m1_readdatavalid}, 32'd0);
        tick();
        idle();
        #1;
        check("A_rdv1",   {31'd0, bus.m1_readdatavalid}, 32'd1);
        check("A_data1",  bus.m1_readdata, 32'hA500_0020);
        check("A_rdv0n",  {31'd0, bus.m0_readdatavalid}, 32'd0);
        check("A_nodat0", bus.m0_readdata, 32'd0);
        tick();

        // B: partial write then read-back.
        bus.m0_write = 1'b1; bus.m0_address = 12'h005;
        bus.m0_writedata = 32'hDEAD_BEEF; bus.m0_byteenable = 4'h3;
        #1;
        check("B_wr",   {31'd0, bus.ram_write}, 32'd1);
        check("B_be",   {28'd0, bus.ram_byteenable}, 32'h3);
        tick();
        bus.m0_write = 1'b0; bus.m0_read = 1'b1; bus.m0_byteenable = 4'hF;
        #1;
        check("B_wr_nordv", {31'd0, bus.m0_readdatavalid}, 32'd0);
        tick();
        idle();
        #1;
        check("B_rdv",  {31'd0, bus.m0_readdatavalid}, 32'd1);
        check("B_data", bus.m0_readdata, 32'hA500_BEEF);
        tick();

        // D: boundary reads from m1, last valid word then first invalid word.
        bus.m1_read = 1'b1; bus.m1_address = 12'hA3F;
        #1;
        check("D_cs_in", {31'd0, bus.ram_chipselect}, 32'd1);
        tick();
        bus.m1_address = 12'hA40;
        #1;
        check("D_cs_oor",   {31'd0, bus.ram_chipselect}, 32'd0);
        check("D_wait_oor", {31'd0, bus.m1_waitrequest}, 32'd0);
        check("D_data_in",  bus.m1_readdata, 32'hA500_0A3F);
        check("D_err0",     {31'd0, bus.oor_err}, 32'd0);
        tick();
        idle();
        #1;
        check("D_rdv",  {31'd0, bus.m1_readdatavalid}, 32'd1);
        check("D_zero", bus.m1_readdata, 32'd0);
        check("D_err1", {31'd0, bus.oor_err}, 32'd1);
        tick();
        check("D_err_sticky", {31'd0, bus.oor_err}, 32'd1);

        // C: continuous contention for 8 cycles, strict alternation.
        begin
            int g0;
            int g1;
            g0 = 0; g1 = 0;
            bus.m0_read = 1'b1; bus.m0_address = 12'h100;
            bus.m1_read = 1'b1; bus.m1_address = 12'h200;
            for (int i = 0; i < 8; i++) begin
                #1;
                check($sformatf("C_wait0_%0d", i), {31'd0, bus.m0_waitrequest}, {31'd0, (i % 2) == 1});
                check($sformatf("C_wait1_%0d", i), {31'd0, bus.m1_waitrequest}, {31'd0, (i % 2) == 0});
                if (!bus.m0_waitrequest) g0++;
                if (!bus.m1_waitrequest) g1++;
                if (i > 0) begin
                    if ((i % 2) == 1) check($sformatf("C_d0_%0d", i), bus.m0_readdata, 32'hA500_0100);
                    else              check($sformatf("C_d1_%0d", i), bus.m1_readdata, 32'hA500_0200);
                end
                tick();
            end
            idle();
            #1;
            check("C_g0", g0, 32'd4);
            check("C_g1", g1, 32'd4);
            check("C_last_rdv1", {31'd0, bus.m1_readdatavalid}, 32'd1);
            tick();
        end

        // F: read and write together act as a write.
        bus.m0_read = 1'b1; bus.m0_write = 1'b1; bus.m0_address = 12'h001;
        bus.m0_writedata = 32'h1234_5678; bus.m0_byteenable = 4'hF;
        #1;
        check("F_wr", {31'd0, bus.ram_write}, 32'd1);
        tick();
        idle();
        #1;
        check("F_nordv", {31'd0, bus.m0_readdatavalid}, 32'd0);
        bus.m0_read = 1'b1;
        tick();
        idle();
        #1;
        check("F_data", bus.m0_readdata, 32'h1234_5678);
        tick();

        // E: reset right after a granted read drops it and restores priority.
        bus.m0_read = 1'b1; bus.m0_address = 12'h010;
        tick();
        idle();
        reset = 1'b1;
        #1;
        check("E_rdv_in_rst", {30'd0, bus.m1_readdatavalid, bus.m0_readdatavalid}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("E_rdv_after", {30'd0, bus.m1_readdatavalid, bus.m0_readdatavalid}, 32'd0);
        check("E_err", {31'd0, bus.oor_err}, 32'd0);
        tick();
        check("E_rdv_later", {30'd0, bus.m1_readdatavalid, bus.m0_readdatavalid}, 32'd0);
        bus.m0_read = 1'b1; bus.m1_read = 1'b1;
        #1;
        check("E_wait0", {31'd0, bus.m0_waitrequest}, 32'd0);
        check("E_wait1", {31'd0, bus.m1_waitrequest}, 32'd1);
        tick();
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nios_sys_onchip_mem_arbiter.md
NIOS_SYS_ONCHIP_MEM_ARBITER -- requirements
Module: nios_sys_onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2624, number of valid RAM words.
REQ-002 SHALL have parameter ADDR_W, default 12, word-address width.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports m0_address/m1_address  input  ADDR_W  requester word address (m0 = Nios data master, m1 = accelerator).
REQ-006 SHALL have ports m0_read/m1_read and m0_write/m1_write  input  1 each  transfer requests.
REQ-007 SHALL have ports m0_byteenable/m1_byteenable  input  4  and  m0_writedata/m1_writedata  input  32.
REQ-008 SHALL have ports m0_waitrequest/m1_waitrequest  output  1  transfer not accepted this cycle.
REQ-009 SHALL have ports m0_readdata/m1_readdata  output  32  and  m0_readdatavalid/m1_readdatavalid  output  1.
REQ-010 SHALL have ports ram_address  output  ADDR_W;  ram_byteenable  output  4;  ram_writedata  output  32;  ram_chipselect, ram_write, ram_clken  output  1.
REQ-011 SHALL have port ram_readdata  input  32, valid one cycle after the address is presented (unregistered RAM output).
REQ-012 SHALL have port oor_err  output  1  sticky out-of-range access flag.

Function
REQ-013 SHALL treat requester N as requesting when mN_read or mN_write is high; if both are high, the transfer is a write and the read is ignored.
REQ-014 SHALL grant at most one requester per cycle, combinationally from the current requests and a registered priority pointer.
REQ-015 SHALL grant the sole requester when only one requests; when both request, it SHALL grant the requester the pointer favours.
REQ-016 SHALL set the pointer, on the clock edge after any grant, to favour the requester not granted (round-robin), and SHALL leave it unchanged in cycles without a grant.
REQ-017 SHALL drive mN_waitrequest = requesting(N) AND NOT granted(N); a granted transfer completes in that cycle.
REQ-018 SHALL drive ram_address, ram_byteenable and ram_writedata from the granted requester, and from m0 when no requester is granted.
REQ-019 SHALL assert ram_chipselect when a grant exists, and ram_write when the granted transfer is a write.
REQ-020 SHALL hold ram_clken at 1.
REQ-021 SHALL treat an address >= DEPTH as out of range: it is still granted, and ram_chipselect and ram_write are forced to 0.
REQ-022 SHALL set oor_err on the clock edge after any granted out-of-range access, and SHALL hold it until reset.
REQ-023 SHALL register a granted read as pending, capturing owner and out-of-range bit; on the next cycle it SHALL assert the owner's readdatavalid for exactly one cycle.
REQ-024 SHALL drive the owner's readdata with ram_readdata, or with 0 for an out-of-range read; non-owner readdata and readdatavalid SHALL be 0.
REQ-025 SHALL sustain back-to-back reads at one per cycle, including alternating owners, with fixed latency 1 and no reordering.
REQ-026 SHALL never assert readdatavalid for a write.

Reset
REQ-027 SHALL, while reset is high, drive both waitrequests 0 and both readdatavalids 0, drive readdata 0, clear oor_err and the pending-read register, and set the pointer to favour m0.
REQ-028 SHALL drop any pending read when reset asserts mid-operation; no readdatavalid SHALL appear after reset is released.
REQ-029 SHALL gate ram_chipselect and ram_write to 0 while reset is high.

Verification
REQ-030 Scenario A: after reset, m0 and m1 both read in the same cycle (addr 0x010 and 0x020). m0 is granted first with m1_waitrequest=1. Next cycle m1 is granted and m0_readdatavalid=1 with RAM[0x010]. The cycle after, m1_readdatavalid=1 with RAM[0x020].
REQ-031 Scenario B: m0 writes 0xDEADBEEF to 0x005 with byteenable 0x3, then reads 0x005. Readdata shows the lower 16 bits updated and the upper 16 bits preserved, one cycle after the read grant.
REQ-032 Scenario C: both requesters hold read requests continuously for 8 cycles. Grants alternate m0, m1, m0, ... and each requester gets 4 grants.
REQ-033 Scenario D: m1 reads 0xA40 (2624), which is out of range. ram_chipselect=0, m1_readdatavalid=1 with 0x00000000 next cycle, and oor_err=1 and stays 1.
REQ-034 Scenario E: reset pulses in the cycle after a granted read. No readdatavalid follows, oor_err=0, and the next simultaneous request is granted to m0.
REQ-035 Scenario F: m0 asserts read and write together to 0x001 with data 0x12345678. A write occurs and no readdatavalid follows.
